bcd_digit_collector: RTL and testbench

//  Upstream feeder for bcd_to_bin. Takes ASCII characters from a byte stream (UART RX / keypad)

---
 rtl/bcd_collect_pkg.sv | 34 +++
 rtl/bcd_digit_collector_if.sv | 22 ++
 rtl/bcd_digit_collector.sv | 99 +++++++++
 tb/tb_bcd_digit_collector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_collect_pkg.sv
// Shared types for the BCD digit collector: FSM states, ASCII codes and character classifier.
package bcd_collect_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    CH_DIGIT,
    CH_TERM,
    CH_ESC,
    CH_EDIT,
    CH_OTHER
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] ch);
    if (ch >= ASCII_0 && ch <= ASCII_9)          return CH_DIGIT;
    else if (ch == ASCII_CR || ch == ASCII_LF)   return CH_TERM;
    else if (ch == ASCII_ESC)                    return CH_ESC;
    else if (ch == ASCII_BS || ch == ASCII_DEL)  return CH_EDIT;
    else                                         return CH_OTHER;
  endfunction

endpackage

// File: rtl/bcd_digit_collector_if.sv
// Character stream in and BCD word / converter handshake out; slave is the collector side.
interface bcd_digit_collector_if #(
  parameter int unsigned BCD_DIGITS = 4
);
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       rx_ready;
  logic [BCD_DIGITS-1:0][3:0] bcd_out;
  logic                       start;
  logic                       conv_rdy;
  logic                       conv_done;

  modport master (
    output rx_data, rx_valid, conv_rdy, conv_done,
    input  rx_ready, bcd_out, start
  );

  modport slave (
    input  rx_data, rx_valid, conv_rdy, conv_done,
    output rx_ready, bcd_out, start
  );
endinterface

// File: rtl/bcd_digit_collector.sv
// Assembles ASCII decimal digits into a packed BCD word (newest digit in [0]) for bcd_to_bin.
// Define BCD_COLLECT_BACKSPACE_EN to let BS/DEL remove the newest digit.
module bcd_digit_collector
  import bcd_collect_pkg::*;
#(
  parameter int unsigned BCD_DIGITS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  bcd_digit_collector_if.slave               bus,
  output logic [$clog2(BCD_DIGITS+1)-1:0]    digit_cnt,
  output logic                               ovf
);

  localparam int unsigned      CNT_W    = $clog2(BCD_DIGITS+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BCD_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                     state;
  logic [BCD_DIGITS-1:0][3:0] shl;

  // Written as a loop so a single-digit build needs no empty slice.
  always_comb begin
    shl    = '0;
    shl[0] = bus.rx_data[3:0];
    for (int unsigned i = 1; i < BCD_DIGITS; i++) shl[i] = bus.bcd_out[i-1];
  end

`ifdef BCD_COLLECT_BACKSPACE_EN
  logic [BCD_DIGITS-1:0][3:0] shr;

  always_comb begin
    shr = '0;
    for (int unsigned i = 0; i + 1 < BCD_DIGITS; i++) shr[i] = bus.bcd_out[i+1];
  end
`endif

  // start depends on conv_rdy directly so it fires in the first ready cycle of ISSUE.
  always_comb begin
    bus.rx_ready = !rst && (state == COLLECT);
    bus.start    = !rst && (state == ISSUE) && bus.conv_rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      bus.bcd_out <= '0;
      digit_cnt   <= '0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.rx_valid) begin
            case (classify(bus.rx_data))
              CH_DIGIT: begin
                if (digit_cnt < CNT_FULL) begin
                  bus.bcd_out <= shl;
                  digit_cnt   <= digit_cnt + CNT_ONE;
                end else begin
                  ovf <= 1'b1;
                end
              end
              CH_TERM: begin
                if (digit_cnt != '0) state <= ISSUE;
              end
              CH_ESC: begin
                bus.bcd_out <= '0;
                digit_cnt   <= '0;
                ovf         <= 1'b0;
              end
`ifdef BCD_COLLECT_BACKSPACE_EN
              CH_EDIT: begin
                if (digit_cnt != '0) begin
                  bus.bcd_out <= shr;
                  digit_cnt   <= digit_cnt - CNT_ONE;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        ISSUE: begin
          if (bus.conv_rdy) state <= WAIT;
        end
        WAIT: begin
          if (bus.conv_done) begin
            state       <= COLLECT;
            bus.bcd_out <= '0;
            digit_cnt   <= '0;
            ovf         <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Scoreboard bench for bcd_digit_collector with a behavioural bcd_to_bin stand-in downstream.
module tb_bcd_digit_collector;
  import bcd_collect_pkg::*;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] digit_cnt;
  logic       ovf;

  bcd_digit_collector_if #(.BCD_DIGITS(N)) bus();

  bcd_digit_collector #(.BCD_DIGITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .digit_cnt (digit_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*N-1:0] word;
    logic           ovf;
    int             cnt;
  } exp_t;

  exp_t sb[$];
  int   bin_q[$];
  int   mq[$];
  logic m_ovf     = 1'b0;
  logic in_conv   = 1'b0;
  logic rdy_hold  = 1'b0;
  logic long_busy = 1'b0;
  int   n_pass    = 0;
  int   n_total   = 0;
  int   conv_bin  = 0;
  int   busy      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference word: digits in arrival order, last one in the low nibble.
  function automatic logic [4*N-1:0] m_word();
    logic [4*N-1:0] w = '0;
    foreach (mq[i]) w = (w << 4) | (4*N)'(mq[i]);
    return w;
  endfunction

  function automatic int m_dec();
    int v = 0;
    foreach (mq[i]) v = v * 10 + mq[i];
    return v;
  endfunction

  function automatic int bcd_dec(input logic [4*N-1:0] w);
    int v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 10 + int'(w[4*i +: 4]);
    return v;
  endfunction

  task automatic model_accept(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) begin
      if (mq.size() < N) mq.push_back(int'(c) - 48);
      else m_ovf = 1'b1;
    end else if (c == ASCII_CR || c == ASCII_LF) begin
      if (mq.size() > 0) begin
        sb.push_back('{m_word(), m_ovf, mq.size()});
        bin_q.push_back(m_dec());
        in_conv = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
      end
    end else if (c == ASCII_ESC) begin
      mq.delete();
      m_ovf = 1'b0;
    end
`ifdef BCD_COLLECT_BACKSPACE_EN
    else if (c == ASCII_BS || c == ASCII_DEL) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [7:0] c);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    bus.rx_data  = c;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.rx_ready) begin
      chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    model_accept(c);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((in_conv || bin_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (in_conv || bin_q.size() != 0) chk("idle_timeout", 32'(in_conv), 32'd0);
    @(posedge clk); #1;
  endtask

  // Converter stand-in: drops conv_rdy while busy, pulses conv_done at the end.
  initial begin
    bus.conv_rdy  = 1'b0;
    bus.conv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.start) begin
        conv_bin = bcd_dec(bus.bcd_out);
        busy     = long_busy ? 30 : int'($urandom_range(1, 5));
      end
      @(posedge clk); #2;
      bus.conv_done = 1'b0;
      if (busy > 0) begin
        bus.conv_rdy = 1'b0;
        busy--;
        if (busy == 0) bus.conv_done = 1'b1;
      end else begin
        bus.conv_rdy = !rdy_hold;
      end
    end
  end

  // Monitor: pops the scoreboard on start/done and tracks held state every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.start) begin
          chk("start_needs_conv_rdy", 32'(bus.conv_rdy), 32'd1);
          if (sb.size() == 0) begin
            chk("unexpected_start", 32'(bus.start), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("bcd_out_at_start", 32'(bus.bcd_out), 32'(e.word));
            chk("ovf_at_start", 32'(ovf), 32'(e.ovf));
            chk("digit_cnt_at_start", 32'(digit_cnt), 32'(e.cnt));
          end
        end
        if (bus.conv_done) begin
          if (bin_q.size() == 0) chk("unexpected_done", 32'(bin_q.size()), 32'd1);
          else chk("bin_out", 32'(conv_bin), 32'(bin_q.pop_front()));
        end
        if (in_conv) begin
          chk("rx_ready_busy", 32'(bus.rx_ready), 32'd0);
          if (bus.conv_done) in_conv = 1'b0;
        end else begin
          chk("rx_ready_collect", 32'(bus.rx_ready), 32'd1);
          chk("digit_cnt", 32'(digit_cnt), 32'(mq.size()));
          chk("ovf", 32'(ovf), 32'(m_ovf));
          chk("bcd_out", 32'(bus.bcd_out), 32'(m_word()));
        end
      end
    end
  end

  logic [7:0] specials [6] = '{8'h0D, 8'h0A, 8'h1B, 8'h08, 8'h7F, 8'h78};

  initial begin
    int t;
    int r;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_bcd_out", 32'(bus.bcd_out), 32'd0);
    chk("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_str("1234");  send(ASCII_CR);                wait_idle();
    send_str("8191");  send(ASCII_CR); send(ASCII_LF); wait_idle();
    send_str("12345"); send(ASCII_CR);                wait_idle();

    rdy_hold = 1'b1;
    send_str("7"); send(ASCII_CR);
    repeat (10) @(posedge clk);
    #1 rdy_hold = 1'b0;
    wait_idle();

    send_str("99"); send(ASCII_ESC); send_str("05"); send(ASCII_CR); wait_idle();
    send_str("123"); send(ASCII_BS); send_str("4"); send(ASCII_CR); wait_idle();
    send_str("6"); send(ASCII_DEL); send(ASCII_DEL); send_str("x3"); send(ASCII_LF); wait_idle();

    // Reset while the collector waits for a long conversion.
    long_busy = 1'b1;
    send_str("5"); send(ASCII_CR);
    t = 0;
    while ((bus.conv_rdy || sb.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wait", 32'(bus.conv_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("start_during_rst", 32'(bus.start), 32'd0);
    chk("rx_ready_during_rst", 32'(bus.rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_conv = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    long_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_bcd_out", 32'(bus.bcd_out), 32'd0);
    chk("post_rst_digit_cnt", 32'(digit_cnt), 32'd0);
    chk("post_rst_start", 32'(bus.start), 32'd0);
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    wait_idle();
    send(ASCII_CR);
    repeat (5) @(posedge clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 10) send(8'h30 + 8'(r));
      else send(specials[r-10]);
    end
    send(ASCII_CR);
    wait_idle();
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
